// File: rtl/clk_monitor.sv
// rtl/clk_monitor.sv - measures clk_in period and high time in clk cycles, with range and stopped-clock detection
`timescale 1ns/1ps
module clk_monitor #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_in,
   input  logic             en,
   input  logic             clr_stats,
   input  logic [CNT_W-1:0] lo_limit,
   input  logic [CNT_W-1:0] hi_limit,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic [CNT_W-1:0] period_min,
   output logic [CNT_W-1:0] period_max,
   output logic             meas_valid,
   output logic             out_of_range,
   output logic             fault,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced, synced_d, rd;
   logic [CNT_W-1:0]       cnt_q, hcnt_q;
   logic                   load, meas, tmo, clr_tmo, count_en, oor_now;

   assign synced  = sync_q[SYNC_STAGES-1];
   assign rd      = synced & ~synced_d;
   // An inverted window (lo > hi) makes every interval fail one of the two tests.
   assign oor_now = (cnt_q < lo_limit) || (cnt_q > hi_limit);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '0;
         synced_d <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], clk_in};
         synced_d <= synced;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      meas     = 1'b0;
      tmo      = 1'b0;
      clr_tmo  = 1'b0;
      count_en = 1'b0;
      if (!en) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_ARM;
            S_ARM: begin
               if (rd) begin
                  load    = 1'b1;
                  clr_tmo = 1'b1;
                  state_d = S_MEAS;
               end
            end
            S_MEAS: begin
               if (rd) begin
                  load    = 1'b1;
                  meas    = 1'b1;
                  clr_tmo = 1'b1;
               end else if (cnt_q == CNT_MAX) begin
                  // Counter saturated: treat clk_in as stopped and discard this interval.
                  tmo     = 1'b1;
                  state_d = S_ARM;
               end else begin
                  count_en = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         hcnt_q <= '0;
      end else if (load) begin
         cnt_q  <= {{(CNT_W-1){1'b0}}, 1'b1};
         hcnt_q <= {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (count_en) begin
         cnt_q  <= cnt_q + 1'b1;
         hcnt_q <= hcnt_q + CNT_W'(synced);
      end else begin
         cnt_q  <= '0;
         hcnt_q <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         period       <= '0;
         high_time    <= '0;
         period_min   <= '1;
         period_max   <= '0;
         meas_valid   <= 1'b0;
         out_of_range <= 1'b0;
         fault        <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         meas_valid <= meas;
         if (meas) begin
            period       <= cnt_q;
            high_time    <= hcnt_q;
            out_of_range <= oor_now;
         end
         // Cleared stats sit at min=all-ones/max=0 so the next sample loads both.
         if (meas && clr_stats) begin
            period_min <= cnt_q;
            period_max <= cnt_q;
         end else if (clr_stats) begin
            period_min <= '1;
            period_max <= '0;
         end else if (meas) begin
            if (cnt_q < period_min) period_min <= cnt_q;
            if (cnt_q > period_max) period_max <= cnt_q;
         end
         if (clr_stats)                   fault <= (meas & oor_now) | tmo;
         else if ((meas & oor_now) | tmo) fault <= 1'b1;
         if (tmo)          timeout <= 1'b1;
         else if (clr_tmo) timeout <= 1'b0;
      end
   end

endmodule

// File: tb/tb_clk_monitor.sv
// tb/tb_clk_monitor.sv - randomized and directed bench for clk_monitor with an event-level reference model
`timescale 1ns/1ps
module tb_clk_monitor;

   localparam int W = 8;

   logic         clk = 1'b0, rst = 1'b1, clk_in = 1'b0, en = 1'b0, clr_stats = 1'b0;
   logic [W-1:0] lo_limit = 8'd1, hi_limit = 8'd255;
   logic [W-1:0] period, high_time, period_min, period_max;
   logic         meas_valid, out_of_range, fault, timeout;

   int n_vec = 0, n_err = 0;

   typedef struct {int per; int hi; bit oor; int mn; int mx; bit flt;} exp_t;
   exp_t q[$];
   exp_t ce;

   // Reference model state: rises are tracked in clk ticks since clk_in is driven on clk negedges.
   bit m_armed, m_prev, m_fault, m_timeout;
   int m_since, m_hcnt, m_min, m_max;
   bit prev_mv;

   always #5 clk = ~clk;

   clk_monitor #(.CNT_W(W), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .clk_in(clk_in), .en(en), .clr_stats(clr_stats),
      .lo_limit(lo_limit), .hi_limit(hi_limit),
      .period(period), .high_time(high_time), .period_min(period_min), .period_max(period_max),
      .meas_valid(meas_valid), .out_of_range(out_of_range), .fault(fault), .timeout(timeout)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_armed = 0; m_prev = 0; m_fault = 0; m_timeout = 0;
      m_since = 0; m_hcnt = 0; m_min = 255; m_max = 0;
      q.delete();
   endtask

   task automatic model_step(input bit v, input bit clr);
      bit   rise;
      exp_t e;
      rise = v && !m_prev;
      if (m_armed && m_since >= 256) begin
         m_timeout = 1; m_fault = 1; m_armed = 0;
      end
      if (rise && en) begin
         if (m_armed) begin
            e.per = m_since;
            e.hi  = m_hcnt;
            e.oor = (m_since < int'(lo_limit)) || (m_since > int'(hi_limit));
            if (clr) begin
               m_min = e.per; m_max = e.per; m_fault = e.oor;
            end else begin
               if (e.per < m_min) m_min = e.per;
               if (e.per > m_max) m_max = e.per;
               m_fault = m_fault | e.oor;
            end
            e.mn = m_min; e.mx = m_max; e.flt = m_fault;
            q.push_back(e);
         end else if (clr) begin
            m_min = 255; m_max = 0; m_fault = 0;
         end
         m_armed = 1; m_timeout = 0;
      end else if (clr) begin
         m_min = 255; m_max = 0; m_fault = 0;
      end
      if (!en) m_armed = 0;
      if (rise) begin
         m_since = 0; m_hcnt = 0;
      end
      m_since++;
      m_hcnt += int'(v);
      m_prev = v;
   endtask

   // cmod is the clear as the model sees it: a pulse timed onto a rise's detect cycle counts at that rise.
   task automatic tick(input bit v, input bit cdrv, input bit cmod);
      @(negedge clk);
      clk_in    = v;
      clr_stats = cdrv;
      model_step(v, cmod);
   endtask

   task automatic per(input int h, input int l, input int cc);
      for (int c = 0; c < h + l; c++)
         tick(c < h, c == cc, (cc == 2) ? (c == 0) : (c == cc));
   endtask

   task automatic chk_reset();
      chk("rst_period", period, 0);
      chk("rst_high", high_time, 0);
      chk("rst_max", period_max, 0);
      chk("rst_min", period_min, 255);
      chk("rst_mv", meas_valid, 0);
      chk("rst_oor", out_of_range, 0);
      chk("rst_fault", fault, 0);
      chk("rst_timeout", timeout, 0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1; clk_in = 0; clr_stats = 0;
      model_reset();
      @(posedge clk);
      #1;
      chk_reset();
      @(negedge clk);
      rst = 0;
   endtask

   always @(posedge clk) begin
      #1;
      if (rst) begin
         prev_mv = 0;
      end else begin
         if (meas_valid) begin
            chk("mv_width", prev_mv, 0);
            if (q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL mv_spurious: meas_valid=1 with no measurement due at %0t", $time);
            end else begin
               ce = q.pop_front();
               chk("period", period, ce.per);
               chk("high_time", high_time, ce.hi);
               chk("out_of_range", out_of_range, ce.oor);
               chk("period_min", period_min, ce.mn);
               chk("period_max", period_max, ce.mx);
               chk("fault", fault, ce.flt);
            end
         end
         prev_mv = meas_valid;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      apply_reset();
      en = 1;
      repeat (3) tick(0, 0, 0);

      // 100 ns / 30 ns high
      repeat (6) per(3, 7, -1);
      chk("lit_period10", period, 10);
      chk("lit_high3", high_time, 3);

      // alternating 90/110 ns, then clear coincident with an 11
      repeat (4) begin
         per(4, 5, -1);
         per(4, 7, -1);
      end
      chk("lit_min9", period_min, 9);
      chk("lit_max11", period_max, 11);
      per(3, 7, 2);
      chk("lit_clr_min11", period_min, 11);
      chk("lit_clr_max11", period_max, 11);

      // window 8..12 with one 130 ns period
      lo_limit = 8'd8; hi_limit = 8'd12;
      per(3, 10, -1);
      per(3, 7, -1);
      chk("lit_period13", period, 13);
      chk("lit_oor13", out_of_range, 1);
      repeat (2) per(3, 7, -1);
      chk("lit_fault_sticky", fault, 1);
      per(3, 7, 5);
      chk("lit_fault_cleared", fault, 0);
      per(3, 5, -1);
      per(3, 9, -1);
      chk("lit_period8", period, 8);
      chk("lit_oor8", out_of_range, 0);
      per(3, 7, -1);
      chk("lit_period12", period, 12);
      chk("lit_oor12", out_of_range, 0);
      per(3, 7, -1);
      chk("lit_fault_edges", fault, 0);

      // stopped clock
      per(3, 7, -1);
      repeat (300) tick(0, 0, 0);
      chk("lit_timeout", timeout, 1);
      chk("lit_timeout_fault", fault, 1);
      per(3, 8, -1);
      chk("lit_timeout_clr", timeout, 0);
      per(3, 7, -1);
      chk("lit_after_timeout", period, 11);

      // reset mid-period
      repeat (2) per(3, 7, -1);
      repeat (3) tick(1, 0, 0);
      repeat (2) tick(0, 0, 0);
      apply_reset();
      repeat (3) per(3, 8, -1);
      chk("lit_after_rst", period, 11);

      // enable dropped mid-period
      repeat (2) per(3, 7, -1);
      repeat (3) tick(1, 0, 0);
      repeat (2) tick(0, 0, 0);
      en = 0;
      repeat (5) tick(0, 0, 0);
      repeat (2) per(3, 6, -1);
      chk("lit_hold_period", period, 10);
      en = 1;
      repeat (2) per(3, 9, -1);
      per(3, 7, -1);
      chk("lit_reenable", period, 12);

      // randomized periods, windows and clears
      for (int i = 0; i < 200; i++) begin
         int h, l, cc, sel;
         h   = int'($urandom_range(2, 8));
         l   = int'($urandom_range(2, 12));
         lo_limit = 8'($urandom_range(4, 14));
         hi_limit = 8'($urandom_range(4, 20));
         sel = int'($urandom_range(0, 7));
         cc  = (sel == 0) ? 2 : (sel == 1) ? 3 : -1;
         per(h, l, cc);
      end
      repeat (8) tick(0, 0, 0);
      chk("queue_drained", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/clk_monitor.md
# clk_monitor

Synthesizable monitor that measures a clock under test (`clk_in`) against the system clock `clk`, the on-chip counterpart of the bench clock generator's frequency printout. It reports each period and high time in `clk` cycles, tracks min/max period (jitter envelope), flags periods outside a programmable window, and detects a stopped clock. It sits directly downstream of the clock source, and its measurement outputs feed status/CSR logic.

## Interface
- `CNT_W`, 16: width of the period/high-time counters and all measurement outputs.
- `SYNC_STAGES`, 2: flip-flop synchronizer depth for `clk_in`; minimum 2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clk_in`  in  1  clock under test, asynchronous to `clk`.
- `en`  in  1  measurement enable.
- `clr_stats`  in  1  single-cycle pulse; clears min/max and `fault`.
- `lo_limit`  in  CNT_W  minimum allowed period, in `clk` cycles.
- `hi_limit`  in  CNT_W  maximum allowed period, in `clk` cycles.
- `period`  out  CNT_W  last measured period.
- `high_time`  out  CNT_W  high cycles within the last measured period.
- `period_min` / `period_max`  out  CNT_W  extremes since reset or `clr_stats`.
- `meas_valid`  out  1  one-cycle pulse when `period`/`high_time` update.
- `out_of_range`  out  1  qualifies `meas_valid`; period < `lo_limit` or > `hi_limit`.
- `fault`  out  1  sticky OR of `out_of_range` and `timeout`.
- `timeout`  out  1  no rising edge seen for 2^CNT_W−1 cycles; level signal.

## Operation
- `clk_in` passes through `SYNC_STAGES` flops. Rise detect `rd` = synced & ~synced_d. Validity requires `clk_in` high and low phases of at least 2 `clk` cycles each; faster clocks are out of scope.
- FSM states:
  - IDLE: entered on reset or when `en`=0. Counters are zeroed. Outputs hold their values.
  - ARM: waits for `rd`. On `rd`, counters are loaded and the state goes to MEAS. No measurement is produced.
  - MEAS: on each `rd`, the interval is latched and counting restarts.
- Transitions: IDLE→ARM when `en`=1. Any state→IDLE when `en`=0, taking priority over `rd`.
- Counting:
  - On `rd`, `cnt` is loaded with 1. `hcnt` is loaded with 1 (the detect cycle sees synced=1).
  - Each later cycle: `cnt`+1; `hcnt`+1 when synced=1.
  - On the next `rd`: `period`=`cnt`, `high_time`=`hcnt`.
  - Net effect: rd at cycles t0 and t1 gives period = t1−t0.
- Timeout: if `cnt` reaches all-ones in MEAS, `timeout` goes to 1, `fault` goes to 1, and the state goes to ARM. `timeout` clears on the next `rd`. The interval that follows is not measured; it is re-armed.
- Min/max: updated on every `meas_valid`.
  - After reset/`clr_stats` the first measurement loads both `period_min` and `period_max`.
  - Later measurements use unsigned compare.
  - Equal values are in range for the limit check.
- `clr_stats` and `meas_valid` in the same cycle: min=max=the new period. `fault` takes only the new `out_of_range`; a pending `timeout` is also cleared.
- Limits are sampled in the cycle of `rd`. If `lo_limit` > `hi_limit`, every measurement is out of range.

## Timing
- Reset values:
  - `period`=0, `high_time`=0, `period_max`=0.
  - `period_min`=all-ones.
  - `meas_valid`=0, `out_of_range`=0, `fault`=0, `timeout`=0.
  - FSM state = IDLE.
- Latency: a `clk_in` rise produces `rd` SYNC_STAGES+1 cycles later (±1 cycle of sampling uncertainty). `period`, `high_time`, `meas_valid`, `out_of_range`, min/max and `fault` are all registered and visible in cycle `rd`+1.
- `meas_valid` is never asserted on the first `rd` after ARM, and never in IDLE.
- `timeout` asserts in the cycle after `cnt` = 2^CNT_W−1.
- A reset mid-measurement discards the partial interval. The first `rd` after `en`=1 only arms the block.

## Test plan
- `clk` 10 ns; `clk_in` 100 ns period, 30 ns high; `en`=1 → first rise gives no `meas_valid`. Every following rise gives `period`=10, `high_time`=3, and `meas_valid` lasts exactly 1 cycle.
- `clk_in` periods alternating 90/110 ns → `period` alternates 9/11, `period_min`=9, `period_max`=11. Then `clr_stats` coincident with a period-11 `meas_valid` → min=max=11.
- `lo_limit`=8, `hi_limit`=12; inject one 130 ns period → `out_of_range`=1 with `period`=13, `fault` stays 1. Later 100 ns periods leave `fault`=1 until `clr_stats`. Periods of exactly 8 and 12 are in range.
- `CNT_W`=8; hold `clk_in` low after a rise → `timeout`=1 after 255 cycles and `fault`=1. On the next rise `timeout`=0 with no `meas_valid`; the rise after that gives a valid measurement.
- Assert `rst` halfway through a period → all outputs return to reset values the next cycle. After release, the first rise only arms the block and the second gives a correct `period`.
- Drop `en` mid-period → no `meas_valid`, outputs hold. Re-enable → arm, then a correct measurement on the second rise.
